// File: rtl/mips_regfile_sb.sv
// Parametrised register file with optional zero register and write-to-read bypass,
// plus a per-register pending-write scoreboard for RAW hazard detection in decode.
module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic              signal_reg_write,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              signal_issue,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              issue_ready,
  output logic              busy_1,
  output logic              busy_2,
  output logic              sb_error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [PEND_W-1:0] cnt  [DEPTH];

  logic wr_en;
  logic inc_en;
  logic dec_en;
  logic underflow;

  function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Register 0 (when hardwired) is excluded from both writes and tracking, so cnt[0] never moves.
  assign wr_en     = signal_reg_write & ~rst & ~is_zero(write_reg);
  assign inc_en    = signal_issue & issue_ready & ~rst & ~is_zero(issue_reg);
  assign dec_en    = wr_en & (cnt[write_reg] != '0);
  assign underflow = wr_en & (cnt[write_reg] == '0);

  assign issue_ready = (cnt[issue_reg] != CNT_MAX);
  assign busy_1      = (cnt[read_reg_1] != '0);
  assign busy_2      = (cnt[read_reg_2] != '0);

  always_comb begin
    read_data_1 = regs[read_reg_1];
    if (is_zero(read_reg_1))
      read_data_1 = '0;
    else if ((BYPASS != 0) && wr_en && (write_reg == read_reg_1))
      read_data_1 = write_data;
  end

  always_comb begin
    read_data_2 = regs[read_reg_2];
    if (is_zero(read_reg_2))
      read_data_2 = '0;
    else if ((BYPASS != 0) && wr_en && (write_reg == read_reg_2))
      read_data_2 = write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_error <= 1'b0;
    end else begin
      if (wr_en)
        regs[write_reg] <= write_data;
      // An issue and a retiring write to the same register cancel out.
      for (int i = 0; i < DEPTH; i++) begin
        if (inc_en && (issue_reg == ADDR_W'(i)) && !(dec_en && (write_reg == ADDR_W'(i))))
          cnt[i] <= cnt[i] + PEND_W'(1);
        else if (dec_en && (write_reg == ADDR_W'(i)) && !(inc_en && (issue_reg == ADDR_W'(i))))
          cnt[i] <= cnt[i] - PEND_W'(1);
      end
      if (underflow)
        sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed bench for mips_regfile_sb with default parameters (zero reg, bypass, PEND_W=2).
module tb_mips_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] write_data;
  logic [2:0]  write_reg;
  logic        signal_reg_write;
  logic [2:0]  read_reg_1;
  logic [2:0]  read_reg_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic        signal_issue;
  logic [2:0]  issue_reg;
  logic        issue_ready;
  logic        busy_1;
  logic        busy_2;
  logic        sb_error;

  int total = 0;
  int bad   = 0;

  mips_regfile_sb dut (
    .clk(clk), .rst(rst),
    .write_data(write_data), .write_reg(write_reg), .signal_reg_write(signal_reg_write),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .signal_issue(signal_issue), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .busy_1(busy_1), .busy_2(busy_2), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    signal_reg_write = 1'b0;
    signal_issue     = 1'b0;
  endtask

  task automatic do_issue(input logic [2:0] r);
    signal_issue = 1'b1; issue_reg = r;
    tick();
    idle();
  endtask

  task automatic do_write(input logic [2:0] r, input logic [31:0] d);
    signal_reg_write = 1'b1; write_reg = r; write_data = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_write(3'd5, 32'hDEADBEEF);
    read_reg_1 = 3'd5; #1;
    total++; if (read_data_1 !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_reset_r5 got=%h exp=%h", read_data_1, 32'hDEADBEEF); end
    total++; if (sb_error !== 1'b1) begin bad++; $display("FAIL pre_reset_sb_error got=%b exp=1", sb_error); end
    // Write and issue during reset must be ignored, and not bypassed.
    rst = 1'b1;
    signal_reg_write = 1'b1; write_reg = 3'd5; write_data = 32'hCAFEF00D;
    signal_issue = 1'b1; issue_reg = 3'd5;
    #1;
    total++; if (read_data_1 !== 32'hDEADBEEF) begin bad++; $display("FAIL reset_no_bypass got=%h exp=%h", read_data_1, 32'hDEADBEEF); end
    tick();
    idle(); rst = 1'b0; read_reg_2 = 3'd7; #1;
    total++; if (read_data_1 !== 32'h0) begin bad++; $display("FAIL reset_r5 got=%h exp=0", read_data_1); end
    total++; if (read_data_2 !== 32'h0) begin bad++; $display("FAIL reset_r7 got=%h exp=0", read_data_2); end
    total++; if (busy_1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_1); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
    total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL reset_sb_error got=%b exp=0", sb_error); end
  endtask

  task automatic test_zero_reg();
    read_reg_1 = 3'd0; issue_reg = 3'd0;
    signal_reg_write = 1'b1; write_reg = 3'd0; write_data = 32'h12345678;
    signal_issue = 1'b1;
    #1;
    total++; if (read_data_1 !== 32'h0) begin bad++; $display("FAIL zero_same_cycle got=%h exp=0", read_data_1); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL zero_issue_ready got=%b exp=1", issue_ready); end
    tick();
    idle(); #1;
    total++; if (read_data_1 !== 32'h0) begin bad++; $display("FAIL zero_read got=%h exp=0", read_data_1); end
    total++; if (busy_1 !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy_1); end
    total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL zero_sb_error got=%b exp=0", sb_error); end
  endtask

  task automatic test_bypass();
    do_issue(3'd3);
    do_issue(3'd3);
    do_write(3'd3, 32'h11);
    read_reg_1 = 3'd3; read_reg_2 = 3'd3; #1;
    total++; if (read_data_1 !== 32'h11) begin bad++; $display("FAIL bypass_pre got=%h exp=11", read_data_1); end
    signal_reg_write = 1'b1; write_reg = 3'd3; write_data = 32'h22; #1;
    total++; if (read_data_1 !== 32'h22) begin bad++; $display("FAIL bypass_port1 got=%h exp=22", read_data_1); end
    total++; if (read_data_2 !== 32'h22) begin bad++; $display("FAIL bypass_port2 got=%h exp=22", read_data_2); end
    total++; if (busy_1 !== 1'b1) begin bad++; $display("FAIL bypass_busy_same_cycle got=%b exp=1", busy_1); end
    read_reg_2 = 3'd6; #1;
    total++; if (read_data_2 !== 32'h0) begin bad++; $display("FAIL bypass_other_reg got=%h exp=0", read_data_2); end
    tick();
    idle(); #1;
    total++; if (read_data_1 !== 32'h22) begin bad++; $display("FAIL bypass_next got=%h exp=22", read_data_1); end
    total++; if (busy_1 !== 1'b0) begin bad++; $display("FAIL bypass_busy_next got=%b exp=0", busy_1); end
    total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL bypass_sb_error got=%b exp=0", sb_error); end
  endtask

  task automatic test_saturation();
    read_reg_1 = 3'd4; issue_reg = 3'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL sat_ready_%0d got=%b exp=1", k, issue_ready); end
      do_issue(3'd4);
    end
    #1;
    total++; if (busy_1 !== 1'b1) begin bad++; $display("FAIL sat_busy got=%b exp=1", busy_1); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL sat_not_ready got=%b exp=0", issue_ready); end
    do_issue(3'd4);
    #1;
    total++; if (busy_1 !== 1'b1) begin bad++; $display("FAIL sat_4th_busy got=%b exp=1", busy_1); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL sat_4th_ready got=%b exp=0", issue_ready); end
    do_write(3'd4, 32'h41);
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL sat_ready_after_wb got=%b exp=1", issue_ready); end
    do_write(3'd4, 32'h42);
    signal_reg_write = 1'b1; write_reg = 3'd4; write_data = 32'h43; #1;
    total++; if (busy_1 !== 1'b1) begin bad++; $display("FAIL sat_busy_last_wb got=%b exp=1", busy_1); end
    tick();
    idle(); #1;
    total++; if (busy_1 !== 1'b0) begin bad++; $display("FAIL sat_drained got=%b exp=0", busy_1); end
    total++; if (read_data_1 !== 32'h43) begin bad++; $display("FAIL sat_data got=%h exp=43", read_data_1); end
    total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL sat_sb_error got=%b exp=0", sb_error); end
  endtask

  task automatic test_simultaneous();
    do_issue(3'd2);
    do_issue(3'd7);
    read_reg_1 = 3'd2; issue_reg = 3'd2;
    signal_issue = 1'b1; signal_reg_write = 1'b1; write_reg = 3'd2; write_data = 32'h2222;
    tick();
    idle(); #1;
    total++; if (busy_1 !== 1'b1) begin bad++; $display("FAIL simul_same_busy got=%b exp=1", busy_1); end
    total++; if (read_data_1 !== 32'h2222) begin bad++; $display("FAIL simul_same_data got=%h exp=2222", read_data_1); end
    do_write(3'd2, 32'h2223);
    #1;
    total++; if (busy_1 !== 1'b0) begin bad++; $display("FAIL simul_same_count_one got=%b exp=0", busy_1); end
    read_reg_1 = 3'd6; read_reg_2 = 3'd7;
    signal_issue = 1'b1; issue_reg = 3'd6;
    signal_reg_write = 1'b1; write_reg = 3'd7; write_data = 32'h7777;
    tick();
    idle(); #1;
    total++; if (busy_1 !== 1'b1) begin bad++; $display("FAIL simul_r6_busy got=%b exp=1", busy_1); end
    total++; if (busy_2 !== 1'b0) begin bad++; $display("FAIL simul_r7_clear got=%b exp=0", busy_2); end
    total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL simul_sb_error got=%b exp=0", sb_error); end
    do_write(3'd6, 32'h6666);
  endtask

  task automatic test_underflow();
    read_reg_1 = 3'd1; read_reg_2 = 3'd5;
    signal_reg_write = 1'b1; write_reg = 3'd1; write_data = 32'hA5A5A5A5; #1;
    total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL uf_same_cycle got=%b exp=0", sb_error); end
    tick();
    idle(); #1;
    total++; if (read_data_1 !== 32'hA5A5A5A5) begin bad++; $display("FAIL uf_data got=%h exp=a5a5a5a5", read_data_1); end
    total++; if (busy_1 !== 1'b0) begin bad++; $display("FAIL uf_busy got=%b exp=0", busy_1); end
    total++; if (sb_error !== 1'b1) begin bad++; $display("FAIL uf_sb_error got=%b exp=1", sb_error); end
    do_issue(3'd5);
    do_issue(3'd5);
    tick(); tick();
    total++; if (sb_error !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", sb_error); end
    total++; if (busy_2 !== 1'b1) begin bad++; $display("FAIL uf_r5_pending got=%b exp=1", busy_2); end
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    total++; if (sb_error !== 1'b0) begin bad++; $display("FAIL uf_cleared got=%b exp=0", sb_error); end
    total++; if (busy_2 !== 1'b0) begin bad++; $display("FAIL uf_pending_discarded got=%b exp=0", busy_2); end
    total++; if (read_data_1 !== 32'h0) begin bad++; $display("FAIL uf_r1_cleared got=%h exp=0", read_data_1); end
  endtask

  initial begin
    rst = 1'b1;
    write_data = '0; write_reg = '0; signal_reg_write = 1'b0;
    read_reg_1 = '0; read_reg_2 = '0;
    signal_issue = 1'b0; issue_reg = '0;
    tick();
    rst = 1'b0;
    test_reset();
    test_zero_reg();
    test_bypass();
    test_saturation();
    test_simultaneous();
    test_underflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
